regfile_writeback: RTL and testbench

Write-back stage directly upstream of the 64-bit, 32-entry register file; owns its single write port (`wen`, `wa`, `wd`). Two producers compete for that port: single-cycle ALU results and multi-cycle memory/load results. Each producer has a small FIFO behind a valid/ready handshake, and a starvation-bounded priority arbiter drains the FIFOs into a registered write port. A pending-write mask feeds hazard/stall logic in decode.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/regfile_writeback.sv | 134 +++++++++++++
 tb/tb_regfile_writeback.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared types and default sizes for the register-file write-back.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

   localparam int W_DEF          = 64;
   localparam int R_DEF          = 32;
   localparam int AW_DEF         = $clog2(R_DEF);
   localparam int DEPTH_DEF      = 2;
   localparam int STARVE_MAX_DEF = 4;

   typedef struct packed {
      logic [AW_DEF-1:0] wa;
      logic [W_DEF-1:0]  wd;
   } wb_req_t;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_MEM = 1'b1
   } wb_src_e;

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : Small write-request FIFO exposing per-entry valid/address taps.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n_i,
   input  logic                               push_i,
   input  wb_req_t                            data_i,
   input  logic                               pop_i,
   output logic                               full_o,
   output logic                               empty_o,
   output wb_req_t                            head_o,
   output logic [DEPTH-1:0]                   ent_valid_o,
   output logic [DEPTH-1:0][AW_DEF-1:0]       ent_wa_o
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0] wr_q;
   logic [PW:0] rd_q;
   logic [PW:0] cnt;
   wb_req_t     mem_q [DEPTH];

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign cnt     = wr_q - rd_q;
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (cnt == (PW+1)'(DEPTH));
   assign head_o  = mem_q[rd_q[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && !full_o) wr_q <= wr_q + 1'b1;
         if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_q[PW-1:0]] <= data_i;
   end

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_ent
         logic [PW-1:0] off;
         assign off            = PW'(i) - rd_q[PW-1:0];
         assign ent_valid_o[i] = ({1'b0, off} < cnt);
         assign ent_wa_o[i]    = mem_q[i].wa;
      end
   endgenerate

endmodule : wb_fifo

`default_nettype wire

// File: rtl/regfile_writeback.sv
// ============================================================================
//  Module   : regfile_writeback
//  Purpose  : Arbitrates ALU and memory write-backs onto the register-file port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_writeback
   import wb_pkg::*;
#(
   parameter int W          = W_DEF,
   parameter int R          = R_DEF,
   parameter int AW         = $clog2(R),
   parameter int DEPTH      = DEPTH_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst_n_i,
   input  logic          alu_valid_i,
   output logic          alu_ready_o,
   input  logic [AW-1:0] alu_wa_i,
   input  logic [W-1:0]  alu_wd_i,
   input  logic          mem_valid_i,
   output logic          mem_ready_o,
   input  logic [AW-1:0] mem_wa_i,
   input  logic [W-1:0]  mem_wd_i,
   output logic          wen_o,
   output logic [W-1:0]  wa_o,
   output logic [W-1:0]  wd_o,
   output logic [R-1:0]  pend_mask_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   wb_req_t                    alu_req, mem_req, alu_head, mem_head, win_req;
   logic                       alu_full, alu_empty, mem_full, mem_empty;
   logic                       alu_push, mem_push, grant_alu, grant_mem, grant_any;
   logic [DEPTH-1:0]           alu_ent_valid, mem_ent_valid;
   logic [DEPTH-1:0][AW-1:0]   alu_ent_wa, mem_ent_wa;
   wb_src_e                    win_src;

   logic          wen_q;
   logic [AW-1:0] wa_q;
   logic [W-1:0]  wd_q;
   logic [SW-1:0] starve_q, starve_d;
   logic [R-1:0]  mask_d;

   assign alu_req = '{wa: alu_wa_i, wd: alu_wd_i};
   assign mem_req = '{wa: mem_wa_i, wd: mem_wd_i};

   // Ready is gated by reset because the FIFO count is already zero while held.
   assign alu_ready_o = rst_n_i && !alu_full;
   assign mem_ready_o = rst_n_i && !mem_full;

   // Writes to r0 finish the handshake but are dropped here.
   assign alu_push = alu_valid_i && alu_ready_o && (alu_wa_i != '0);
   assign mem_push = mem_valid_i && mem_ready_o && (mem_wa_i != '0);

   wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
      .clk        (clk),
      .rst_n_i    (rst_n_i),
      .push_i     (alu_push),
      .data_i     (alu_req),
      .pop_i      (grant_alu),
      .full_o     (alu_full),
      .empty_o    (alu_empty),
      .head_o     (alu_head),
      .ent_valid_o(alu_ent_valid),
      .ent_wa_o   (alu_ent_wa)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
      .clk        (clk),
      .rst_n_i    (rst_n_i),
      .push_i     (mem_push),
      .data_i     (mem_req),
      .pop_i      (grant_mem),
      .full_o     (mem_full),
      .empty_o    (mem_empty),
      .head_o     (mem_head),
      .ent_valid_o(mem_ent_valid),
      .ent_wa_o   (mem_ent_wa)
   );

   assign grant_alu = !alu_empty && (mem_empty || (starve_q == SW'(STARVE_MAX)));
   assign grant_mem = !mem_empty && !grant_alu;
   assign grant_any = grant_alu || grant_mem;
   assign win_src   = grant_alu ? WB_SRC_ALU : WB_SRC_MEM;
   assign win_req   = (win_src == WB_SRC_ALU) ? alu_head : mem_head;

   always_comb begin
      starve_d = starve_q;
      if (alu_empty || grant_alu) begin
         starve_d = '0;
      end else if (grant_mem && (starve_q != SW'(STARVE_MAX))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wen_q    <= 1'b0;
         wa_q     <= '0;
         wd_q     <= '0;
         starve_q <= '0;
      end else begin
         wen_q    <= grant_any;
         starve_q <= starve_d;
         if (grant_any) begin
            wa_q <= win_req.wa;
            wd_q <= win_req.wd;
         end
      end
   end

   assign wen_o = wen_q;
   assign wa_o  = W'(wa_q);
   assign wd_o  = wd_q;

   always_comb begin
      mask_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_ent_valid[i]) mask_d[alu_ent_wa[i]] = 1'b1;
         if (mem_ent_valid[i]) mask_d[mem_ent_wa[i]] = 1'b1;
      end
      if (wen_q) mask_d[wa_q] = 1'b1;
      mask_d[0] = 1'b0;
   end

   assign pend_mask_o = mask_d;

endmodule : regfile_writeback

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
//  Module   : tb_regfile_writeback
//  Purpose  : Scoreboard bench for the register-file write-back arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

   localparam int W  = 64;
   localparam int R  = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst_n_i;
   logic          alu_valid_i, alu_ready_o;
   logic [AW-1:0] alu_wa_i;
   logic [W-1:0]  alu_wd_i;
   logic          mem_valid_i, mem_ready_o;
   logic [AW-1:0] mem_wa_i;
   logic [W-1:0]  mem_wd_i;
   logic          wen_o;
   logic [W-1:0]  wa_o, wd_o;
   logic [R-1:0]  pend_mask_o;

   regfile_writeback dut (
      .clk        (clk),
      .rst_n_i    (rst_n_i),
      .alu_valid_i(alu_valid_i),
      .alu_ready_o(alu_ready_o),
      .alu_wa_i   (alu_wa_i),
      .alu_wd_i   (alu_wd_i),
      .mem_valid_i(mem_valid_i),
      .mem_ready_o(mem_ready_o),
      .mem_wa_i   (mem_wa_i),
      .mem_wd_i   (mem_wd_i),
      .wen_o      (wen_o),
      .wa_o       (wa_o),
      .wd_o       (wd_o),
      .pend_mask_o(pend_mask_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [63:0] wa;
      logic [63:0] wd;
   } exp_t;

   exp_t alu_exp[$];
   exp_t mem_exp[$];
   bit   win_q[$];
   bit   mon_en = 1'b0;
   bit   rec_win = 1'b0;
   bit   saw_mem_full = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Mem data always carries bit 63 set, so the write source is visible on wd_o.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n_i && mon_en) begin
         if (wen_o) begin
            if (wd_o[63]) begin
               chk("mem_write_expected", 64'(mem_exp.size() != 0), 64'd1);
               if (mem_exp.size() != 0) begin
                  e = mem_exp.pop_front();
                  chk("mem_wa", wa_o, e.wa);
                  chk("mem_wd", wd_o, e.wd);
               end
            end else begin
               chk("alu_write_expected", 64'(alu_exp.size() != 0), 64'd1);
               if (alu_exp.size() != 0) begin
                  e = alu_exp.pop_front();
                  chk("alu_wa", wa_o, e.wa);
                  chk("alu_wd", wd_o, e.wd);
               end
            end
            if (rec_win) win_q.push_back(wd_o[63]);
         end
         if (rec_win && mem_valid_i && !mem_ready_o) saw_mem_full = 1'b1;
         if (alu_valid_i && alu_ready_o && alu_wa_i != '0)
            alu_exp.push_back('{64'(alu_wa_i), alu_wd_i});
         if (mem_valid_i && mem_ready_o && mem_wa_i != '0)
            mem_exp.push_back('{64'(mem_wa_i), mem_wd_i});
      end
   end

   initial begin
      int  ka, km;
      bit  acc_a, acc_m;

      rst_n_i     = 1'b0;
      alu_valid_i = 1'b0;
      alu_wa_i    = '0;
      alu_wd_i    = '0;
      mem_valid_i = 1'b0;
      mem_wa_i    = '0;
      mem_wd_i    = '0;

      repeat (2) @(negedge clk);
      chk("rst_wen", 64'(wen_o), 64'd0);
      chk("rst_wa", wa_o, 64'd0);
      chk("rst_wd", wd_o, 64'd0);
      chk("rst_pend", 64'(pend_mask_o), 64'd0);
      chk("rst_alu_ready", 64'(alu_ready_o), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready_o), 64'd0);
      #2 rst_n_i = 1'b1;
      #1;
      chk("post_rst_alu_ready", 64'(alu_ready_o), 64'd1);
      chk("post_rst_mem_ready", 64'(mem_ready_o), 64'd1);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Single uncontended ALU write.
      alu_valid_i = 1'b1;
      alu_wa_i    = AW'(5);
      alu_wd_i    = 64'hDEAD;
      @(posedge clk); #1;
      alu_valid_i = 1'b0;
      @(negedge clk);
      chk("single_c1_wen", 64'(wen_o), 64'd0);
      chk("single_c1_pend5", 64'(pend_mask_o[5]), 64'd1);
      @(negedge clk);
      chk("single_c2_wen", 64'(wen_o), 64'd1);
      chk("single_c2_wa", wa_o, 64'd5);
      chk("single_c2_wd", wd_o, 64'hDEAD);
      chk("single_c2_pend5", 64'(pend_mask_o[5]), 64'd1);
      @(negedge clk);
      chk("single_c3_wen", 64'(wen_o), 64'd0);
      chk("single_c3_pend", 64'(pend_mask_o), 64'd0);
      @(posedge clk); #1;

      // Write to r0 handshakes but never reaches the port.
      alu_valid_i = 1'b1;
      alu_wa_i    = '0;
      alu_wd_i    = 64'h123;
      @(negedge clk);
      chk("r0_ready", 64'(alu_ready_o), 64'd1);
      @(posedge clk); #1;
      alu_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("r0_wen_%0d", i), 64'(wen_o), 64'd0);
         chk($sformatf("r0_pend_%0d", i), 64'(pend_mask_o), 64'd0);
      end
      @(posedge clk); #1;

      // Both producers streaming; upstream holds each request until accepted.
      ka = 0;
      km = 0;
      alu_wa_i    = AW'((ka % 31) + 1);
      alu_wd_i    = 64'(ka);
      mem_wa_i    = AW'((km % 31) + 1);
      mem_wd_i    = {1'b1, 63'(km)};
      rec_win     = 1'b1;
      alu_valid_i = 1'b1;
      mem_valid_i = 1'b1;
      repeat (40) begin
         @(negedge clk);
         acc_a = alu_valid_i && alu_ready_o;
         acc_m = mem_valid_i && mem_ready_o;
         @(posedge clk); #1;
         if (acc_a) begin
            ka++;
            alu_wa_i = AW'((ka % 31) + 1);
            alu_wd_i = 64'(ka);
         end
         if (acc_m) begin
            km++;
            mem_wa_i = AW'((km % 31) + 1);
            mem_wd_i = {1'b1, 63'(km)};
         end
      end
      alu_valid_i = 1'b0;
      mem_valid_i = 1'b0;
      for (int t = 0; t < 60 && (alu_exp.size() != 0 || mem_exp.size() != 0); t++)
         @(negedge clk);
      @(negedge clk);
      rec_win = 1'b0;
      chk("stream_alu_drained", 64'(alu_exp.size()), 64'd0);
      chk("stream_mem_drained", 64'(mem_exp.size()), 64'd0);
      chk("stream_mem_backpressure_seen", 64'(saw_mem_full), 64'd1);
      chk("stream_win_count_ge20", 64'(win_q.size() >= 20), 64'd1);
      for (int i = 0; i < 20; i++) begin
         if (i < win_q.size())
            chk($sformatf("stream_win_%0d", i), 64'(win_q[i]), (i % 5 == 4) ? 64'd0 : 64'd1);
      end
      @(posedge clk); #1;

      // Load both FIFOs, then reset mid-drain.
      alu_valid_i = 1'b1;
      alu_wa_i    = AW'(3);
      alu_wd_i    = 64'h33;
      mem_valid_i = 1'b1;
      mem_wa_i    = AW'(7);
      mem_wd_i    = {1'b1, 63'h77};
      @(posedge clk); #1;
      alu_wa_i    = AW'(4);
      alu_wd_i    = 64'h44;
      mem_wa_i    = AW'(9);
      mem_wd_i    = {1'b1, 63'h99};
      @(posedge clk); #1;
      alu_valid_i = 1'b0;
      mem_valid_i = 1'b0;
      @(negedge clk);
      chk("load_pend", 64'(pend_mask_o), 64'h0000_0298);
      #2 rst_n_i = 1'b0;
      alu_exp.delete();
      mem_exp.delete();
      #1;
      chk("midrst_wen", 64'(wen_o), 64'd0);
      chk("midrst_pend", 64'(pend_mask_o), 64'd0);
      chk("midrst_wd", wd_o, 64'd0);
      chk("midrst_alu_ready", 64'(alu_ready_o), 64'd0);
      chk("midrst_mem_ready", 64'(mem_ready_o), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n_i = 1'b1;
      #1;
      chk("release_alu_ready", 64'(alu_ready_o), 64'd1);
      chk("release_mem_ready", 64'(mem_ready_o), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("release_no_wen_%0d", i), 64'(wen_o), 64'd0);
         chk($sformatf("release_pend_%0d", i), 64'(pend_mask_o), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_regfile_writeback

`default_nettype wire
